// File: rtl/refund_dispenser.sv
// Pays out money - price greedily, one coin per coin_valid/coin_ack handshake, across 4 channels.
// Latency: first coin_valid 3 cycles after start; each later coin 1 SELECT cycle after the previous ack.
// Backpressure: a presented coin (coin_valid, coin_sel) is held until coin_ack; start is ignored while busy.
module refund_dispenser #(
    parameter int W    = 13,
    parameter int DEN0 = 100,
    parameter int DEN1 = 25,
    parameter int DEN2 = 10,
    parameter int DEN3 = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] price,
    input  logic [W-1:0] money,
    input  logic [3:0]   coin_empty,
    input  logic         coin_ack,
    output logic         busy,
    output logic         coin_valid,
    output logic [1:0]   coin_sel,
    output logic [W-1:0] refund,
    output logic [W-1:0] remaining,
    output logic         done,
    output logic         err_funds,
    output logic         residue
);

    typedef enum logic [2:0] {IDLE, CHECK, SELECT, DISPENSE, FINISH, ERROR} state_t;

    state_t       state;
    logic [W-1:0] price_q;
    logic [W-1:0] money_q;
    logic         pick_ok;
    logic [1:0]   pick_idx;

    function automatic logic [W-1:0] den(input logic [1:0] idx);
        case (idx)
            2'd0:    den = W'(DEN0);
            2'd1:    den = W'(DEN1);
            2'd2:    den = W'(DEN2);
            default: den = W'(DEN3);
        endcase
    endfunction

    // Scan from the smallest coin upward so the largest usable coin wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!coin_empty[i] && den(2'(i)) <= remaining && remaining != '0) begin
                pick_ok  = 1'b1;
                pick_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            price_q    <= '0;
            money_q    <= '0;
            busy       <= 1'b0;
            coin_valid <= 1'b0;
            coin_sel   <= 2'd0;
            refund     <= '0;
            remaining  <= '0;
            done       <= 1'b0;
            err_funds  <= 1'b0;
            residue    <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_funds <= 1'b0;
            residue   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        price_q <= price;
                        money_q <= money;
                        busy    <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (money_q < price_q) begin
                        refund    <= '0;
                        remaining <= '0;
                        err_funds <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        refund    <= money_q - price_q;
                        remaining <= money_q - price_q;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_ok) begin
                        coin_sel   <= pick_idx;
                        coin_valid <= 1'b1;
                        state      <= DISPENSE;
                    end else begin
                        done    <= 1'b1;
                        residue <= (remaining != '0);
                        state   <= FINISH;
                    end
                end
                DISPENSE: begin
                    // The selected coin never exceeds remaining, so this cannot wrap.
                    if (coin_ack) begin
                        remaining  <= remaining - den(coin_sel);
                        coin_valid <= 1'b0;
                        state      <= SELECT;
                    end
                end
                FINISH, ERROR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    coin_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refund_dispenser.sv
// Self-checking bench for refund_dispenser: directed scenarios plus randomized transactions
// checked against a greedy change-making model with a randomly stalling hopper.
module tb_refund_dispenser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] price;
    logic [12:0] money;
    logic [3:0]  coin_empty;
    logic        coin_ack;
    logic        busy;
    logic        coin_valid;
    logic [1:0]  coin_sel;
    logic [12:0] refund;
    logic [12:0] remaining;
    logic        done;
    logic        err_funds;
    logic        residue;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    refund_dispenser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .price      (price),
        .money      (money),
        .coin_empty (coin_empty),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .coin_valid (coin_valid),
        .coin_sel   (coin_sel),
        .refund     (refund),
        .remaining  (remaining),
        .done       (done),
        .err_funds  (err_funds),
        .residue    (residue)
    );

    // One full transaction; the bench acts as the coin hopper with random ack delay.
    task automatic run_txn(input string name, input int p, input int m,
                           input logic [3:0] emp, input bit noisy);
        int          dens[4] = '{100, 25, 10, 5};
        bit          exp_err;
        int          exp_ref;
        int          exp_rem;
        int          exp_q[$];
        int          got_q[$];
        bit          found;
        bit          same;
        int          cyc;
        int          wait_n;
        int          ack_cyc;
        bit          prev_valid;
        bit          finished;
        bit          saw_valid;
        logic [1:0]  held_sel;
        logic        got_done;
        logic        got_err;
        logic        got_res;
        logic [12:0] got_rem;
        logic [12:0] got_ref;

        exp_err = (m < p);
        exp_ref = exp_err ? 0 : m - p;
        exp_rem = exp_ref;
        if (!exp_err) begin
            do begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && !emp[i] && dens[i] <= exp_rem) begin
                        exp_q.push_back(i);
                        exp_rem -= dens[i];
                        found = 1'b1;
                    end
                end
            end while (found);
        end

        @(negedge clk);
        start      = 1'b1;
        price      = p[12:0];
        money      = m[12:0];
        coin_empty = emp;
        cyc = 0; wait_n = -1; ack_cyc = -100; prev_valid = 1'b0;
        finished = 1'b0; saw_valid = 1'b0; held_sel = 2'd0;
        got_done = 1'b0; got_err = 1'b0; got_res = 1'b0; got_rem = '0; got_ref = '0;

        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            coin_ack = 1'b0;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b want 1", name, busy);
                end
            end
            if (coin_valid === 1'b1) begin
                saw_valid = 1'b1;
                if (!prev_valid) begin
                    checks++;
                    if (got_q.size() == 0 && cyc != 3) begin
                        errors++;
                        $display("FAIL %s first_coin_latency: got cycle %0d want 3", name, cyc);
                    end else if (got_q.size() != 0 && cyc != ack_cyc + 2) begin
                        errors++;
                        $display("FAIL %s next_coin_latency: got cycle %0d want %0d", name, cyc, ack_cyc + 2);
                    end
                end else begin
                    checks++;
                    if (coin_sel !== held_sel) begin
                        errors++;
                        $display("FAIL %s coin_sel_hold: got %0d want %0d", name, coin_sel, held_sel);
                    end
                end
                held_sel = coin_sel;
                if (wait_n < 0) wait_n = $urandom_range(3, 0);
                if (wait_n == 0) begin
                    coin_ack = 1'b1;
                    got_q.push_back(int'(coin_sel));
                    ack_cyc = cyc;
                    wait_n = -1;
                end else begin
                    wait_n--;
                end
                if (noisy && ($urandom_range(1, 0) == 1)) begin
                    start = 1'b1;
                    price = 13'($urandom_range(500, 0));
                    money = 13'($urandom_range(500, 0));
                end
            end
            prev_valid = (coin_valid === 1'b1) && !coin_ack;
            if (done === 1'b1 || err_funds === 1'b1) begin
                finished = 1'b1;
                got_done = done; got_err = err_funds; got_res = residue;
                got_rem = remaining; got_ref = refund;
            end
        end
        start    = 1'b0;
        coin_ack = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: no done/err_funds after %0d cycles", name, cyc);
        end
        checks++;
        if (got_err !== exp_err || got_done !== !exp_err) begin
            errors++;
            $display("FAIL %s outcome: got done=%b err=%b want done=%b err=%b",
                     name, got_done, got_err, !exp_err, exp_err);
        end
        checks++;
        if (got_ref !== 13'(exp_ref)) begin
            errors++;
            $display("FAIL %s refund: got %0d want %0d", name, got_ref, exp_ref);
        end
        checks++;
        if (got_rem !== 13'(exp_rem)) begin
            errors++;
            $display("FAIL %s remaining: got %0d want %0d", name, got_rem, exp_rem);
        end
        checks++;
        if (got_res !== (!exp_err && exp_rem != 0)) begin
            errors++;
            $display("FAIL %s residue: got %b want %b", name, got_res, (!exp_err && exp_rem != 0));
        end
        same = (got_q.size() == exp_q.size());
        for (int i = 0; i < got_q.size() && same; i++) same = (got_q[i] == exp_q[i]);
        checks++;
        if (!same) begin
            errors++;
            $display("FAIL %s coin_list: got %0d coins %p want %0d coins %p",
                     name, got_q.size(), got_q, exp_q.size(), exp_q);
        end
        if (exp_err) begin
            checks++;
            if (saw_valid || cyc != 2) begin
                errors++;
                $display("FAIL %s err_timing: got cycle %0d coin_valid_seen=%b want cycle 2 none", name, cyc, saw_valid);
            end
        end else begin
            checks++;
            if (cyc != ((exp_q.size() == 0) ? 3 : ack_cyc + 2)) begin
                errors++;
                $display("FAIL %s done_timing: got cycle %0d want %0d", name, cyc,
                         (exp_q.size() == 0) ? 3 : ack_cyc + 2);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err_funds !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: got done=%b err=%b busy=%b valid=%b want all 0",
                     name, done, err_funds, busy, coin_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; price = '0; money = '0; coin_empty = '0; coin_ack = 1'b0;
        #1;
        checks++;
        if ({busy, coin_valid, coin_sel, refund, remaining, done, err_funds, residue} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b sel=%0d refund=%0d rem=%0d done=%b err=%b res=%b want all 0",
                     busy, coin_valid, coin_sel, refund, remaining, done, err_funds, residue);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn("t1_basic", 150, 300, 4'b0000, 1'b0);
        run_txn("t2_funds", 200, 150, 4'b0000, 1'b0);
        run_txn("t3_exact", 75, 75, 4'b0000, 1'b0);
        run_txn("t4_empty_ch0", 50, 200, 4'b0001, 1'b0);
        run_txn("t5_residue", 0, 7, 4'b0000, 1'b0);
        run_txn("start_ignored", 40, 345, 4'b0100, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        start = 1'b1; price = 13'd0; money = 13'd300; coin_empty = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (coin_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (coin_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: coin_valid got %b want 1", coin_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, coin_valid, coin_sel, refund, remaining, done, err_funds, residue} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b valid=%b sel=%0d refund=%0d rem=%0d done=%b want all 0",
                     busy, coin_valid, coin_sel, refund, remaining, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("t6_after_reset", 10, 35, 4'b0000, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_txn("random", int'($urandom_range(600, 0)), int'($urandom_range(900, 0)),
                    4'($urandom_range(15, 0)), bit'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
